watchdog_rst_gen: RTL and testbench

Watchdog that produces the active-low reset request consumed by the reset-release stretcher on the elevator controller board. The controller FSM kicks it periodically. A missed kick raises an early warning, then drives `rst_req_n` low for a fixed pulse. Repeated consecutive trips latch a permanent reset until the block itself is reset.

---
 rtl/watchdog_rst_gen.sv | 199 +++++++++++++++++++
 tb/tb_watchdog_rst_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_rst_gen.sv
`default_nettype none
// ============================================================================
// Module      : watchdog_rst_gen
// Description : Kickable watchdog that generates the active-low reset request
//               for the elevator controller's reset-release stretcher.
//               If a kick is missed, the block first raises a warning, then
//               drives a fixed-length low pulse on rst_req_n. After
//               MAX_TRIPS consecutive trips it latches a permanent reset
//               until rst is asserted.
//
// Ports       : clk        - single clock, rising edge
//               rst        - synchronous active-high reset
//               enable     - arms the watchdog while high
//               kick       - single-cycle service strobe (sampled per cycle)
//               rst_req_n  - registered active-low reset request
//               warn       - registered, high while in the warning window
//               locked     - registered, high once lock-up has latched
//               trip_count - total trips since rst, saturating at 15
//
// Revision    : 1.0 - initial release
// ============================================================================
module watchdog_rst_gen #(
    parameter bit SIMULATION     = 1'b0,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int PULSE_CYCLES   = 16,
    parameter int MAX_TRIPS      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       kick,
    output logic       rst_req_n,
    output logic       warn,
    output logic       locked,
    output logic [3:0] trip_count
);

    // Effective timing constants; SIMULATION swaps in short values so the
    // whole behaviour can be exercised in a few hundred cycles.
    localparam int c_TIMER_MAX = SIMULATION ? 10 : TIMEOUT_CYCLES;
    localparam int c_PULSE     = SIMULATION ? 3  : PULSE_CYCLES;
    localparam int c_WARN_AT   = c_TIMER_MAX / 2;

    // Counter values at which the next transition fires. The counters
    // start at 0 on entry, so each threshold is the "last" value minus one.
    localparam logic [13:0] c_TRIP_AT    = 14'(c_TIMER_MAX - 1);
    localparam logic [13:0] c_WARN_LAST  = 14'(c_WARN_AT - 1);
    localparam logic [7:0]  c_PULSE_LAST = 8'(c_PULSE - 1);
    localparam logic [3:0]  c_MAX_TRIPS  = 4'(MAX_TRIPS);
    localparam logic [3:0]  c_TRIP_SAT   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WARN   = 3'd2,
        ST_TRIP   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [13:0] r_count;
    logic [13:0] w_count_nxt;
    logic [7:0]  r_pcount;
    logic [7:0]  w_pcount_nxt;
    logic [3:0]  r_consec;
    logic [3:0]  w_consec_nxt;
    logic [3:0]  r_trip_count;
    logic [3:0]  w_trip_count_nxt;
    logic        r_rst_req_n;
    logic        w_rst_req_n_nxt;
    logic        r_warn;
    logic        w_warn_nxt;
    logic        r_locked;
    logic        w_locked_nxt;
    logic [3:0]  w_consec_inc;

    // consec never exceeds MAX_TRIPS-1 (<= 14), so this cannot overflow.
    assign w_consec_inc = r_consec + 4'd1;

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed here and
    // registered alongside the state so they change on the same edge as
    // the transition that causes them.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_pcount_nxt     = r_pcount;
        w_consec_nxt     = r_consec;
        w_trip_count_nxt = r_trip_count;
        w_rst_req_n_nxt  = r_rst_req_n;
        w_warn_nxt       = r_warn;
        w_locked_nxt     = r_locked;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_ARMED;
                    w_count_nxt = 14'd0;
                end
            end

            ST_ARMED, ST_WARN: begin
                // Priority: disable, then kick, then timeout, then warning.
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 14'd0;
                    w_warn_nxt  = 1'b0;
                end else if (kick) begin
                    w_state_nxt  = ST_ARMED;
                    w_count_nxt  = 14'd0;
                    w_warn_nxt   = 1'b0;
                    w_consec_nxt = 4'd0;
                end else if (r_count == c_TRIP_AT) begin
                    w_state_nxt     = ST_TRIP;
                    w_rst_req_n_nxt = 1'b0;
                    w_warn_nxt      = 1'b0;
                    w_pcount_nxt    = 8'd0;
                    if (r_trip_count != c_TRIP_SAT) begin
                        w_trip_count_nxt = r_trip_count + 4'd1;
                    end
                end else begin
                    w_count_nxt = r_count + 14'd1;
                    if ((r_state == ST_ARMED) && (r_count == c_WARN_LAST)) begin
                        w_state_nxt = ST_WARN;
                        w_warn_nxt  = 1'b1;
                    end
                end
            end

            ST_TRIP: begin
                // The reset pulse runs to completion regardless of kick or
                // enable, so the controller always sees a full-width reset.
                if (r_pcount == c_PULSE_LAST) begin
                    if (w_consec_inc == c_MAX_TRIPS) begin
                        // rst_req_n is left low here, so entering lock-up
                        // produces no high glitch between pulse and lock.
                        w_state_nxt  = ST_LOCKED;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_ARMED;
                        w_count_nxt     = 14'd0;
                        w_rst_req_n_nxt = 1'b1;
                        w_consec_nxt    = w_consec_inc;
                    end
                end else begin
                    w_pcount_nxt = r_pcount + 8'd1;
                end
            end

            ST_LOCKED: begin
                w_rst_req_n_nxt = 1'b0;
                w_locked_nxt    = 1'b1;
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_count_nxt     = 14'd0;
                w_pcount_nxt    = 8'd0;
                w_rst_req_n_nxt = 1'b1;
                w_warn_nxt      = 1'b0;
                w_locked_nxt    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count      <= 14'd0;
            r_pcount     <= 8'd0;
            r_consec     <= 4'd0;
            r_trip_count <= 4'd0;
            r_rst_req_n  <= 1'b1;
            r_warn       <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_pcount     <= w_pcount_nxt;
            r_consec     <= w_consec_nxt;
            r_trip_count <= w_trip_count_nxt;
            r_rst_req_n  <= w_rst_req_n_nxt;
            r_warn       <= w_warn_nxt;
            r_locked     <= w_locked_nxt;
        end
    end

    assign rst_req_n  = r_rst_req_n;
    assign warn       = r_warn;
    assign locked     = r_locked;
    assign trip_count = r_trip_count;

endmodule
`default_nettype wire

// File: tb/tb_watchdog_rst_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_watchdog_rst_gen
// Description : Self-checking bench for watchdog_rst_gen (short simulation
//               constants). A driver applies directed and random stimulus and
//               pushes the reference model's expected outputs into a queue;
//               a monitor pops one entry per cycle and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_watchdog_rst_gen;

    localparam int c_TMAX  = 10;
    localparam int c_PULSE = 3;
    localparam int c_WARN  = c_TMAX / 2;
    localparam int c_MAXT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       kick = 1'b0;
    logic       rst_req_n;
    logic       warn;
    logic       locked;
    logic [3:0] trip_count;

    always #5 clk = ~clk;

    watchdog_rst_gen #(
        .SIMULATION     (1'b1),
        .TIMEOUT_CYCLES (10000),
        .PULSE_CYCLES   (16),
        .MAX_TRIPS      (c_MAXT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .kick       (kick),
        .rst_req_n  (rst_req_n),
        .warn       (warn),
        .locked     (locked),
        .trip_count (trip_count)
    );

    typedef struct packed {
        logic       rst_req_n;
        logic       warn;
        logic       locked;
        logic [3:0] trip_count;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // ------------------------------------------------------------------
    // Reference model: elapsed cycles since arming/kick, remaining pulse
    // cycles, consecutive-trip tally and total trips, as plain integers.
    // ------------------------------------------------------------------
    bit m_armed  = 1'b0;
    bit m_locked = 1'b0;
    int m_elapsed    = 0;
    int m_pulse_left = 0;
    int m_consec     = 0;
    int m_trips      = 0;

    function automatic void model_step(bit r, bit en, bit k);
        if (r) begin
            m_armed = 0; m_locked = 0; m_elapsed = 0;
            m_pulse_left = 0; m_consec = 0; m_trips = 0;
        end else if (m_locked) begin
            // lock-up holds until reset
        end else if (m_pulse_left > 0) begin
            m_pulse_left--;
            if (m_pulse_left == 0) begin
                if (m_consec + 1 == c_MAXT) begin
                    m_locked = 1;
                end else begin
                    m_consec++;
                    m_armed   = 1;
                    m_elapsed = 0;
                end
            end
        end else if (m_armed) begin
            if (!en) begin
                m_armed = 0; m_elapsed = 0;
            end else if (k) begin
                m_elapsed = 0; m_consec = 0;
            end else if (m_elapsed == c_TMAX - 1) begin
                m_armed = 0;
                m_pulse_left = c_PULSE;
                if (m_trips < 15) m_trips++;
            end else begin
                m_elapsed++;
            end
        end else if (en) begin
            m_armed = 1; m_elapsed = 0;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.rst_req_n  = !(m_locked || (m_pulse_left > 0));
        e.warn       = m_armed && (m_elapsed >= c_WARN);
        e.locked     = m_locked;
        e.trip_count = 4'(m_trips);
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Driver helpers: one call = one clock edge = one expected entry.
    // ------------------------------------------------------------------
    task automatic step(input bit r, input bit en, input bit k);
        exp_t e;
        rst = r; enable = en; kick = k;
        model_step(r, en, k);
        e = model_out();
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0);
    endtask

    task automatic kick_every(input int period, input int total);
        for (int i = 0; i < total; i++) step(1'b0, 1'b1, (i % period) == 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs against one queued entry per cycle.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{rst_req_n, warn, locked, trip_count};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got rst_req_n=%b warn=%b locked=%b trip_count=%0d, expected rst_req_n=%b warn=%b locked=%b trip_count=%0d",
                             $time, a.rst_req_n, a.warn, a.locked, a.trip_count,
                             e.rst_req_n, e.warn, e.locked, e.trip_count);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // reset, then idle with enable low and stray kicks
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // arm with no kicks: warn, trip, pulse, re-arm; then kick clears consec
        run(16, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // regular servicing
        kick_every(8, 200);
        kick_every(7, 100);

        // kick exactly on the timeout cycle
        step(1'b0, 1'b1, 1'b1);
        run(9, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        // disable exactly on the timeout cycle
        run(9, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run(3, 1'b0);

        // three consecutive trips -> lock-up; inputs ignored; rst releases
        run(45, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 1'b0);
        run(4, 1'b0);

        // two trips, kick, two trips -> not locked
        run(30, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        run(30, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // reset in the middle of a trip pulse
        run(11, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run(3, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // many isolated trips -> trip_count saturates at 15
        for (int j = 0; j < 18; j++) begin
            run(14, 1'b1);
            step(1'b0, 1'b1, 1'b1);
        end

        // randomized operation
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 19) != 0),
                 1'($urandom_range(0, 11) == 0));

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
